// File: rtl/adc_acq_pkg.sv
// Shared types and defaults for the AD9283 acquisition sequencer.
// The post-wake routing helper is shared by the IDLE fast path and the WAKE exit.
package adc_acq_pkg;

   localparam int DIV_W_DEF       = 16;
   localparam int LEN_W_DEF       = 16;
   localparam int WAKE_CYCLES_DEF = 64;
   localparam int DATA_W          = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAKE = 2'd1,
      ST_TRIG = 2'd2,
      ST_CAP  = 2'd3
   } state_t;

   function automatic state_t post_wake_state(input logic trig_en);
      if (trig_en) begin
         post_wake_state = ST_TRIG;
      end else begin
         post_wake_state = ST_CAP;
      end
   endfunction

endpackage

// File: rtl/adc_clk_div.sv
// ADC_CLK generator: half-period of div+1 CLK cycles, with a one-cycle strobe
// in the first CLK cycle after ADC_CLK has fallen.
module adc_clk_div
   import adc_acq_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             adc_clk,
   output logic             stb
);

   logic [DIV_W-1:0] r_cnt;
   logic             r_adc_clk;
   logic             r_stb;
   logic             w_tc;

   assign w_tc = (r_cnt == div);

   // Half-period counter, ADC_CLK toggle and falling-edge strobe; idle parks the clock low.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt     <= '0;
         r_adc_clk <= 1'b0;
         r_stb     <= 1'b0;
      end else if (!en) begin
         r_cnt     <= '0;
         r_adc_clk <= 1'b0;
         r_stb     <= 1'b0;
      end else if (w_tc) begin
         r_cnt     <= '0;
         r_adc_clk <= ~r_adc_clk;
         r_stb     <= r_adc_clk;
      end else begin
         r_cnt     <= r_cnt + DIV_W'(1);
         r_stb     <= 1'b0;
      end
   end

   assign adc_clk = r_adc_clk;
   assign stb     = r_stb;

endmodule

// File: rtl/adc_acq_sequencer.sv
// AD9283 acquisition sequencer: power/wake control, optional trigger wait and
// fixed-length burst capture onto a single-entry valid/ready output register.
module adc_acq_sequencer
   import adc_acq_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEF,
   parameter int LEN_W       = LEN_W_DEF,
   parameter int WAKE_CYCLES = WAKE_CYCLES_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              cfg_trig_en,
   input  logic              cfg_keep_on,
   input  logic              start,
   input  logic              abort,
   input  logic              trig,
   output logic              ADC_CLK,
   output logic              ADC_PWR,
   input  logic [DATA_W-1:0] ADC_Din,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam int                WAKE_W    = $clog2(WAKE_CYCLES + 1);
   localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

   state_t             r_state;
   logic [DIV_W-1:0]   r_div_q;
   logic [LEN_W-1:0]   r_len_q;
   logic               r_trig_en_q;
   logic [WAKE_W-1:0]  r_wake_cnt;
   logic [LEN_W-1:0]   r_smp_cnt;
   logic               r_fin;
   logic               r_pwr;
   logic               r_busy;
   logic               r_done;
   logic [DATA_W-1:0]  r_m_data;
   logic               r_m_valid;
   logic               r_overrun;

   state_t             w_state_nx;
   logic               w_pwr_nx;
   logic               w_start_acc;
   logic               w_sample;
   logic               w_done_nx;
   logic               w_stb;
   logic               w_adc_clk;
   logic               w_en;
   logic [DIV_W-1:0]   w_div;

   // The divider follows the next state so ADC_CLK parks low on the very cycle IDLE is entered.
   assign w_en  = (w_state_nx != ST_IDLE) || !w_pwr_nx;
   assign w_div = w_start_acc ? cfg_div : r_div_q;

   adc_clk_div #(.DIV_W(DIV_W)) u_clk_div (
      .CLK     (CLK),
      .RST     (RST),
      .en      (w_en),
      .div     (w_div),
      .adc_clk (w_adc_clk),
      .stb     (w_stb)
   );

   // Next-state, power request and sample/done decode.
   always_comb begin
      w_state_nx  = r_state;
      w_pwr_nx    = r_pwr;
      w_start_acc = 1'b0;
      w_sample    = 1'b0;
      w_done_nx   = 1'b0;
      if (abort) begin
         w_state_nx = ST_IDLE;
         if ((r_state != ST_IDLE) && !cfg_keep_on) begin
            w_pwr_nx = 1'b1;
         end else begin
            w_pwr_nx = r_pwr;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  w_start_acc = 1'b1;
                  w_pwr_nx    = 1'b0;
                  if (cfg_keep_on && !r_pwr) begin
                     w_state_nx = post_wake_state(cfg_trig_en);
                  end else begin
                     w_state_nx = ST_WAKE;
                  end
               end else begin
                  w_state_nx = ST_IDLE;
               end
            end
            ST_WAKE: begin
               if (w_stb && (r_wake_cnt == WAKE_LAST)) begin
                  w_state_nx = post_wake_state(r_trig_en_q);
               end else begin
                  w_state_nx = ST_WAKE;
               end
            end
            ST_TRIG: begin
               if (w_stb && trig) begin
                  w_state_nx = ST_CAP;
                  w_sample   = 1'b1;
               end else begin
                  w_state_nx = ST_TRIG;
               end
            end
            ST_CAP: begin
               if (r_fin) begin
                  w_state_nx = ST_IDLE;
                  w_done_nx  = 1'b1;
                  if (!cfg_keep_on) begin
                     w_pwr_nx = 1'b1;
                  end else begin
                     w_pwr_nx = r_pwr;
                  end
               end else if (w_stb) begin
                  w_sample = 1'b1;
               end else begin
                  w_sample = 1'b0;
               end
            end
            default: begin
               w_state_nx = ST_IDLE;
            end
         endcase
      end
   end

   // State, power pin, status flags and burst configuration capture.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_pwr       <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div_q     <= '0;
         r_len_q     <= '0;
         r_trig_en_q <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_pwr   <= w_pwr_nx;
         r_busy  <= (w_state_nx != ST_IDLE);
         r_done  <= w_done_nx;
         if (w_start_acc) begin
            r_div_q     <= cfg_div;
            r_len_q     <= cfg_len;
            r_trig_en_q <= cfg_trig_en;
         end
      end
   end

   // Wake strobe count and burst sample count; r_fin marks the last sample taken.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wake_cnt <= '0;
         r_smp_cnt  <= '0;
         r_fin      <= 1'b0;
      end else if (w_start_acc) begin
         r_wake_cnt <= '0;
         r_smp_cnt  <= '0;
         r_fin      <= 1'b0;
      end else if (w_state_nx == ST_IDLE) begin
         r_fin      <= 1'b0;
      end else begin
         if ((r_state == ST_WAKE) && w_stb) begin
            r_wake_cnt <= r_wake_cnt + WAKE_W'(1);
         end
         if (w_sample) begin
            r_smp_cnt <= r_smp_cnt + LEN_W'(1);
            if (r_smp_cnt == r_len_q) begin
               r_fin <= 1'b1;
            end
         end
      end
   end

   // Output register: a new sample always overwrites, flagging overrun if it was still unread.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_m_data  <= '0;
         r_m_valid <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (abort) begin
            r_m_valid <= 1'b0;
         end else if (w_sample) begin
            r_m_valid <= 1'b1;
         end else if (m_ready) begin
            r_m_valid <= 1'b0;
         end
         if (w_sample) begin
            r_m_data <= ADC_Din;
         end
         if (w_start_acc) begin
            r_overrun <= 1'b0;
         end else if (w_sample && r_m_valid && !m_ready) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign ADC_CLK = w_adc_clk;
   assign ADC_PWR = r_pwr;
   assign m_data  = r_m_data;
   assign m_valid = r_m_valid;
   assign busy    = r_busy;
   assign done    = r_done;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed bench for adc_acq_sequencer; ADC_Din counts ADC_CLK rising edges so
// the n-th strobe after a start captures value n.
module tb_adc_acq_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] cfg_div = 16'd1;
   logic [15:0] cfg_len = 16'd3;
   logic        cfg_trig_en = 1'b0;
   logic        cfg_keep_on = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        trig = 1'b0;
   logic        ADC_CLK;
   logic        ADC_PWR;
   logic [7:0]  ADC_Din;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        busy;
   logic        done;
   logic        overrun;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [7:0]  rise_cnt = 8'd0;
   logic [7:0]  din_base = 8'd0;

   logic [7:0]  smp_q[$];
   int          rise_t[$];
   int          n_done, n_falls, first_vrise, vlast, done_t;
   bit          pwr_any_hi, timeout;

   adc_acq_sequencer dut (
      .CLK(CLK), .RST(RST), .cfg_div(cfg_div), .cfg_len(cfg_len),
      .cfg_trig_en(cfg_trig_en), .cfg_keep_on(cfg_keep_on), .start(start),
      .abort(abort), .trig(trig), .ADC_CLK(ADC_CLK), .ADC_PWR(ADC_PWR),
      .ADC_Din(ADC_Din), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(posedge ADC_CLK) rise_cnt <= rise_cnt + 8'd1;

   assign ADC_Din = rise_cnt - din_base;

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      din_base = rise_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Steps until the burst ends (n_stop==0) or n_stop samples are taken, optionally aborting.
   task automatic run_burst(input int max_cyc, input int trig_fall, input int n_stop, input bit do_abort);
      logic prev_clk, prev_valid;
      smp_q.delete();
      rise_t.delete();
      n_done = 0; n_falls = 0; first_vrise = -1; vlast = -1; done_t = -1;
      pwr_any_hi = 1'b0; timeout = 1'b1;
      prev_clk = ADC_CLK;
      prev_valid = m_valid;
      for (int k = 0; k < max_cyc; k++) begin
         tick();
         if (ADC_CLK && !prev_clk) rise_t.push_back(cyc);
         if (!ADC_CLK && prev_clk) n_falls++;
         if ((trig_fall > 0) && (n_falls == trig_fall)) trig = 1'b1;
         if (m_valid && !prev_valid) begin
            if (first_vrise < 0) first_vrise = cyc;
            vlast = cyc;
         end
         if (m_valid && m_ready) smp_q.push_back(m_data);
         if (ADC_PWR) pwr_any_hi = 1'b1;
         if (done) begin
            n_done++;
            done_t = cyc;
         end
         prev_clk = ADC_CLK;
         prev_valid = m_valid;
         if ((n_stop > 0) && (smp_q.size() == n_stop)) begin
            if (do_abort) begin
               abort = 1'b1;
               tick();
               abort = 1'b0;
            end
            timeout = 1'b0;
            break;
         end
         if ((n_stop == 0) && !busy) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_adc_clk"}, ADC_CLK, 0);
      chk({tag, "_adc_pwr"}, ADC_PWR, 1);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_m_data"},  m_data, 0);
      chk({tag, "_busy"},    busy, 0);
      chk({tag, "_done"},    done, 0);
      chk({tag, "_overrun"}, overrun, 0);
   endtask

   initial begin
      int t_s, k_done, k_clk;
      logic [7:0] v;

      // Reset state
      repeat (3) tick();
      chk_reset_outputs("rst");
      RST = 1'b0;
      tick();

      // Basic burst: div=1, len=3, no trigger, always ready
      cfg_div = 16'd1; cfg_len = 16'd3; cfg_trig_en = 1'b0; cfg_keep_on = 1'b0; m_ready = 1'b1;
      pulse_start();
      chk("b1_busy_after_start", busy, 1);
      chk("b1_pwr_after_start", ADC_PWR, 0);
      run_burst(400, 0, 0, 1'b0);
      chk("b1_timeout", timeout, 0);
      chk("b1_adc_clk_period", (rise_t.size() >= 2) ? (rise_t[1] - rise_t[0]) : -1, 4);
      chk("b1_n_samples", smp_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         v = (i < smp_q.size()) ? smp_q[i] : 8'hxx;
         chk($sformatf("b1_sample%0d", i), v, 65 + i);
      end
      chk("b1_n_done", n_done, 1);
      chk("b1_done_latency", done_t - vlast, 1);
      chk("b1_pwr_end", ADC_PWR, 1);
      chk("b1_clk_parked", ADC_CLK, 0);
      tick();
      chk("b1_done_one_cycle", done, 0);

      // Triggered burst: trigger arrives on the 11th strobe in TRIG, len=2
      cfg_trig_en = 1'b1; cfg_len = 16'd2; trig = 1'b0;
      pulse_start();
      run_burst(500, 75, 0, 1'b0);
      trig = 1'b0;
      chk("b2_timeout", timeout, 0);
      chk("b2_n_samples", smp_q.size(), 3);
      for (int i = 0; i < 3; i++) begin
         v = (i < smp_q.size()) ? smp_q[i] : 8'hxx;
         chk($sformatf("b2_sample%0d", i), v, 75 + i);
      end
      chk("b2_n_done", n_done, 1);

      // Consumer stalled for a whole burst of 3
      cfg_trig_en = 1'b0; cfg_len = 16'd2; m_ready = 1'b0;
      tick();
      pulse_start();
      run_burst(400, 0, 0, 1'b0);
      chk("b3_timeout", timeout, 0);
      chk("b3_overrun", overrun, 1);
      chk("b3_m_valid_held", m_valid, 1);
      chk("b3_m_data_last", m_data, 67);
      chk("b3_n_done", n_done, 1);

      // Next start clears overrun; then abort after 2 of 8 samples
      cfg_len = 16'd7;
      pulse_start();
      chk("b4_overrun_cleared", overrun, 0);
      chk("b4_m_valid_kept", m_valid, 1);
      chk("b4_m_data_kept", m_data, 67);
      m_ready = 1'b1;
      run_burst(400, 0, 2, 1'b1);
      chk("b4_timeout", timeout, 0);
      chk("b4_busy_after_abort", busy, 0);
      chk("b4_m_valid_after_abort", m_valid, 0);
      chk("b4_pwr_after_abort", ADC_PWR, 1);
      chk("b4_clk_after_abort", ADC_CLK, 0);
      k_done = n_done;
      k_clk = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) k_done++;
         if (ADC_CLK) k_clk++;
      end
      chk("b4_no_done", k_done, 0);
      chk("b4_clk_held_low", k_clk, 0);

      // keep_on: two back-to-back bursts, the second skips WAKE
      cfg_keep_on = 1'b1; cfg_len = 16'd1;
      pulse_start();
      run_burst(400, 0, 0, 1'b0);
      chk("b5a_timeout", timeout, 0);
      chk("b5a_n_samples", smp_q.size(), 2);
      chk("b5a_pwr_on_after", ADC_PWR, 0);
      repeat (3) tick();
      chk("b5_pwr_between", ADC_PWR, 0);
      pulse_start();
      t_s = cyc;
      run_burst(40, 0, 0, 1'b0);
      chk("b5b_timeout", timeout, 0);
      chk("b5b_fast_first_sample", (first_vrise >= 0) && ((first_vrise - t_s) <= 8), 1);
      chk("b5b_n_samples", smp_q.size(), 2);
      chk("b5b_n_done", n_done, 1);
      chk("b5b_pwr_stayed_on", pwr_any_hi, 0);

      // RST during WAKE, with start held during reset
      cfg_keep_on = 1'b0; cfg_len = 16'd3;
      pulse_start();
      repeat (20) tick();
      chk("b6_in_wake_busy", busy, 1);
      RST = 1'b1; start = 1'b1;
      tick();
      chk_reset_outputs("rst_wake");
      RST = 1'b0; start = 1'b0;
      tick();
      chk("rst_wake_start_ignored", busy, 0);

      // RST during CAP
      pulse_start();
      run_burst(400, 0, 1, 1'b0);
      chk("b7_timeout", timeout, 0);
      chk("b7_in_cap_valid", m_valid, 1);
      RST = 1'b1;
      tick();
      chk_reset_outputs("rst_cap");
      RST = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
